// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequencer for a WIDTH-bit capture/shift/update chain.
// Captures par_in on start, shifts it out LSB-first while shifting ser_in
// into the MSB, then copies the shifted-in word to par_out and pulses done.
module scan_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  input  logic             stall,
  input  logic             abort,
  output logic             ser_out,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] par_out,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // The counter holds at its last value on the final shift instead of
  // wrapping, so it never leaves the range 0..WIDTH-1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] chain_q, chain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  // Next-state and datapath: capture in IDLE, shift/abort/stall in SHIFT,
  // publish the shifted-in word in UPDATE.
  always_comb begin
    state_d   = state_q;
    chain_d   = chain_q;
    cnt_d     = cnt_q;
    par_out_d = par_out_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          chain_d = par_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!stall) begin
          chain_d = {ser_in, chain_q[WIDTH-1:1]};
          if (cnt_q == LAST_CNT) begin
            state_d = UPDATE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      UPDATE: begin
        par_out_d = chain_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      chain_q   <= '0;
      cnt_q     <= '0;
      par_out_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      cnt_q     <= cnt_d;
      par_out_q <= par_out_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    ser_out  = chain_q[0];
    shift_en = (state_q == SHIFT) && !stall;
    busy     = (state_q != IDLE);
    par_out  = par_out_q;
    done     = done_q;
    aborted  = aborted_q;
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: scoreboard bench for scan_chain_ctrl.
// Expected serial bits and end-of-operation results are queued when an
// operation is launched and consumed by a monitor on the falling edge.
module tb_scan_chain_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] par_in;
  logic         ser_in;
  logic         stall;
  logic         abort;
  logic         ser_out;
  logic         shift_en;
  logic         busy;
  logic [W-1:0] par_out;
  logic         done;
  logic         aborted;

  logic loop_en;
  logic ser_fix;

  typedef struct {
    logic b;
    int   id;
  } ser_item_t;

  typedef struct {
    logic         is_abort;
    logic [W-1:0] par;
    int           exp_cyc;
    int           id;
  } end_item_t;

  ser_item_t ser_q[$];
  end_item_t sb_q[$];

  int cyc;
  int n_checks;
  int n_fail;
  int op_id;

  scan_chain_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .par_in   (par_in),
    .ser_in   (ser_in),
    .stall    (stall),
    .abort    (abort),
    .ser_out  (ser_out),
    .shift_en (shift_en),
    .busy     (busy),
    .par_out  (par_out),
    .done     (done),
    .aborted  (aborted)
  );

  assign ser_in = loop_en ? ser_out : ser_fix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Launch one operation: queue its serial bits and its end result, then
  // present start for one edge. lat is edges from accept to result visible.
  task automatic applyStimulus(input logic [W-1:0] par, input logic lb, input int lat,
                               input logic ab, input logic [W-1:0] prev);
    end_item_t e;
    ser_item_t s;
    op_id++;
    par_in  = par;
    loop_en = lb;
    for (int i = 0; i < W; i++) begin
      s.b  = par[i];
      s.id = op_id;
      ser_q.push_back(s);
    end
    e.is_abort = ab;
    e.par      = ab ? prev : (lb ? par : {W{ser_fix}});
    e.exp_cyc  = cyc + 1 + lat;
    e.id       = op_id;
    sb_q.push_back(e);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic drainCheck(input string tag);
    step(W + 6);
    checkOutput({tag, "_sb_empty"}, sb_q.size(), 0);
    checkOutput({tag, "_ser_empty"}, ser_q.size(), 0);
  endtask

  // Falling-edge monitor: serial bits while shifting, results at done/aborted.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) begin
        if (ser_q.size() == 0) begin
          checkOutput("ser_extra", 1, 0);
        end else begin
          ser_item_t s;
          s = ser_q.pop_front();
          checkOutput("ser_out", ser_out, s.b);
        end
      end
      if (done || aborted) begin
        checkOutput("pulse_excl", done & aborted, 0);
        checkOutput("busy_at_end", busy, 0);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_end", 1, 0);
        end else begin
          end_item_t e;
          e = sb_q.pop_front();
          checkOutput("end_kind", aborted, e.is_abort);
          checkOutput("end_cyc", cyc, e.exp_cyc);
          checkOutput("par_out", par_out, e.par);
          if (aborted) begin
            while (ser_q.size() > 0 && ser_q[0].id == e.id) begin
              void'(ser_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    op_id    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    par_in   = '0;
    stall    = 1'b0;
    abort    = 1'b0;
    loop_en  = 1'b0;
    ser_fix  = 1'b0;
    step(2);
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_par_out", par_out, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_shift_en", shift_en, 0);
    step(2);

    $display("[TB] loopback 0xA5");
    applyStimulus(8'hA5, 1'b1, W + 1, 1'b0, '0);
    checkOutput("busy_after_start", busy, 1);
    drainCheck("loop");

    $display("[TB] ser_in tied high, par_in 0x00");
    ser_fix = 1'b1;
    applyStimulus(8'h00, 1'b0, W + 1, 1'b0, '0);
    drainCheck("ones");
    ser_fix = 1'b0;

    $display("[TB] loopback 0xA5 with 3-cycle stall");
    applyStimulus(8'hA5, 1'b1, W + 4, 1'b0, '0);
    step(4);
    stall = 1'b1;
    #1;
    checkOutput("stall_shift_en", shift_en, 0);
    step(3);
    stall = 1'b0;
    drainCheck("stall");

    $display("[TB] abort after 4 shifts");
    applyStimulus(8'h3C, 1'b1, W + 1, 1'b0, '0);
    drainCheck("pre_abort");
    applyStimulus(8'hFF, 1'b1, 5, 1'b1, 8'h3C);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    applyStimulus(8'h81, 1'b1, W + 1, 1'b0, '0);
    drainCheck("abort");

    $display("[TB] start while busy and held through done");
    applyStimulus(8'hA5, 1'b1, W + 1, 1'b0, '0);
    step(2);
    start  = 1'b1;
    par_in = 8'h5A;
    begin
      end_item_t e;
      ser_item_t s;
      op_id++;
      for (int i = 0; i < W; i++) begin
        s.b  = par_in[i];
        s.id = op_id;
        ser_q.push_back(s);
      end
      e.is_abort = 1'b0;
      e.par      = 8'h5A;
      e.exp_cyc  = cyc + 8 + W + 1;
      e.id       = op_id;
      sb_q.push_back(e);
    end
    step(8);
    start = 1'b0;
    drainCheck("b2b");

    $display("[TB] reset mid-shift");
    applyStimulus(8'h77, 1'b1, W + 1, 1'b0, '0);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb_q.delete();
    ser_q.delete();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_par_out", par_out, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_aborted", aborted, 0);
    drainCheck("midrst");
    checkOutput("midrst_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
